// File: rtl/usb_tx_packet_encoder.sv
// USB low-level packet transmitter for token, data and handshake packets.
// Serialises one bit per clock with bit stuffing, NRZI coding and EOP.
module usb_tx_packet_encoder #(
   parameter int MAX_BYTES      = 8,
   parameter int EOP_SE0_CYCLES = 2
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [1:0]                     pkt_class,
   input  logic [3:0]                     pid,
   input  logic [6:0]                     addr,
   input  logic [3:0]                     endp,
   input  logic [8*MAX_BYTES-1:0]         payload,
   input  logic [$clog2(MAX_BYTES+1)-1:0] payload_len,
   output logic                           busy,
   output logic                           done,
   output logic                           bus_en,
   output logic                           dp,
   output logic                           dm
);
   localparam int NB = 8 * MAX_BYTES;
   localparam int LW = $clog2(MAX_BYTES + 1);
   localparam int CW = $clog2(NB + 16 + EOP_SE0_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_PID, S_TOKEN, S_CRC5,
      S_DATA, S_CRC16, S_SE0, S_EOPJ, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] nbits_q, nbits_d;
   logic [2:0]    run_q, run_d;
   logic          lvl_q, lvl_d;
   logic [15:0]   crc_q, crc_d;
   logic [1:0]    cls_q, cls_d;
   logic [7:0]    pidb_q, pidb_d;
   logic [10:0]   tok_q, tok_d;
   logic [NB-1:0] pay_q, pay_d;

   logic [LW-1:0] len_c;
   logic          bitst;
   logic          stuff;
   logic          tx_bit;
   logic          lvl_out;
   logic [4:0]    crc5_nx;
   logic [15:0]   crc16_nx;

   // Pick the current field bit, decide on a stuffed zero, NRZI level, CRC step
   always_comb begin
      bitst  = 1'b0;
      tx_bit = 1'b0;
      unique case (state_q)
         S_SYNC:  begin bitst = 1'b1; tx_bit = (cnt_q == CW'(7)); end
         S_PID:   begin bitst = 1'b1; tx_bit = pidb_q[0]; end
         S_TOKEN: begin bitst = 1'b1; tx_bit = tok_q[0]; end
         S_CRC5:  begin bitst = 1'b1; tx_bit = ~crc_q[4]; end
         S_DATA:  begin bitst = 1'b1; tx_bit = pay_q[0]; end
         S_CRC16: begin bitst = 1'b1; tx_bit = ~crc_q[15]; end
         default: ;
      endcase
      // a pending stuff can still be owed when entering SE0
      stuff = (run_q == 3'd6) && (bitst || state_q == S_SE0);
      if (stuff) tx_bit = 1'b0;
      lvl_out  = tx_bit ? lvl_q : ~lvl_q;
      crc5_nx  = {crc_q[3:0], 1'b0} ^ ((tx_bit ^ crc_q[4]) ? 5'h05 : 5'h00);
      crc16_nx = {crc_q[14:0], 1'b0} ^ ((tx_bit ^ crc_q[15]) ? 16'h8005 : 16'h0000);
   end

   // Next-state and datapath update; counters stall on stuffed bits
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nbits_d = nbits_q;
      run_d   = run_q;
      lvl_d   = lvl_q;
      crc_d   = crc_q;
      cls_d   = cls_q;
      pidb_d  = pidb_q;
      tok_d   = tok_q;
      pay_d   = pay_q;
      len_c   = (payload_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : payload_len;
      if (stuff) begin
         run_d = 3'd0;
         lvl_d = lvl_out;
      end else if (bitst) begin
         run_d = tx_bit ? run_q + 3'd1 : 3'd0;
         lvl_d = lvl_out;
         cnt_d = cnt_q + CW'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SYNC;
               cnt_d   = '0;
               run_d   = '0;
               lvl_d   = 1'b1;
               crc_d   = 16'hFFFF;
               cls_d   = pkt_class;
               pidb_d  = {~pid, pid};
               tok_d   = {endp, addr};
               pay_d   = payload;
               nbits_d = CW'({len_c, 3'b000});
            end
         end
         S_SYNC: begin
            if (!stuff && cnt_q == CW'(7)) begin
               state_d = S_PID;
               cnt_d   = '0;
            end
         end
         S_PID: begin
            if (!stuff) begin
               pidb_d = pidb_q >> 1;
               if (cnt_q == CW'(7)) begin
                  cnt_d = '0;
                  case (cls_q)
                     2'b00:   state_d = S_TOKEN;
                     2'b01:   state_d = (nbits_q == '0) ? S_CRC16 : S_DATA;
                     default: state_d = S_SE0;
                  endcase
               end
            end
         end
         S_TOKEN: begin
            if (!stuff) begin
               tok_d = tok_q >> 1;
               crc_d = {crc_q[15:5], crc5_nx};
               if (cnt_q == CW'(10)) begin
                  state_d = S_CRC5;
                  cnt_d   = '0;
               end
            end
         end
         S_CRC5: begin
            if (!stuff) begin
               crc_d = crc_q << 1;
               if (cnt_q == CW'(4)) begin
                  state_d = S_SE0;
                  cnt_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (!stuff) begin
               pay_d = pay_q >> 1;
               crc_d = crc16_nx;
               if (cnt_q == nbits_q - CW'(1)) begin
                  state_d = S_CRC16;
                  cnt_d   = '0;
               end
            end
         end
         S_CRC16: begin
            if (!stuff) begin
               crc_d = crc_q << 1;
               if (cnt_q == CW'(15)) begin
                  state_d = S_SE0;
                  cnt_d   = '0;
               end
            end
         end
         S_SE0: begin
            if (!stuff) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(EOP_SE0_CYCLES - 1)) begin
                  state_d = S_EOPJ;
                  cnt_d   = '0;
               end
            end
         end
         S_EOPJ:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Line drive: NRZI bits, SE0, trailing J, idle J when released
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      bus_en = 1'b0;
      dp     = 1'b1;
      dm     = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_DONE: done = 1'b1;
         S_EOPJ: begin
            busy   = 1'b1;
            bus_en = 1'b1;
         end
         S_SE0: begin
            busy   = 1'b1;
            bus_en = 1'b1;
            dp     = stuff ? lvl_out : 1'b0;
            dm     = stuff ? ~lvl_out : 1'b0;
         end
         default: begin
            busy   = 1'b1;
            bus_en = 1'b1;
            dp     = lvl_out;
            dm     = ~lvl_out;
         end
      endcase
   end

   // State registers; reset releases the bus at once
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         nbits_q <= '0;
         run_q   <= '0;
         lvl_q   <= 1'b1;
         crc_q   <= 16'hFFFF;
         cls_q   <= '0;
         pidb_q  <= '0;
         tok_q   <= '0;
         pay_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nbits_q <= nbits_d;
         run_q   <= run_d;
         lvl_q   <= lvl_d;
         crc_q   <= crc_d;
         cls_q   <= cls_d;
         pidb_q  <= pidb_d;
         tok_q   <= tok_d;
         pay_q   <= pay_d;
      end
   end

endmodule

// File: tb/tb_usb_tx_packet_encoder.sv
// Bench for usb_tx_packet_encoder: packets are queued as expected bit
// streams, a line monitor de-NRZIs/de-stuffs and checks each packet.
module tb_usb_tx_packet_encoder;
   localparam int EOPN = 2;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  pkt_class;
   logic [3:0]  pid;
   logic [6:0]  addr;
   logic [3:0]  endp;
   logic [63:0] payload;
   logic [3:0]  payload_len;
   logic        busy, done, bus_en, dp, dm;

   usb_tx_packet_encoder #(.MAX_BYTES(8), .EOP_SE0_CYCLES(EOPN)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .pkt_class(pkt_class), .pid(pid), .addr(addr), .endp(endp),
      .payload(payload), .payload_len(payload_len),
      .busy(busy), .done(done), .bus_en(bus_en), .dp(dp), .dm(dm)
   );

   always #5 clock = ~clock;

   typedef struct {
      int           nb;
      logic [127:0] bits;
      int           nst;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int fails  = 0;
   int pkts   = 0;
   int dones  = 0;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // USB CRC16 computed the reflected byte-wise way, returned as the
   // transmitted field with the first bit on the wire as MSB
   function automatic logic [15:0] crc16_ref(logic [63:0] p, int n);
      logic [15:0] c;
      logic [15:0] r;
      c = 16'hFFFF;
      for (int j = 0; j < n; j++) begin
         c = c ^ {8'h00, p[8*j +: 8]};
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 16; k++) r[k] = c[15-k];
      return r;
   endfunction

   function automatic int stuff_count(logic [127:0] b, int n);
      int run;
      int s;
      run = 0;
      s = 0;
      for (int i = 0; i < n; i++) begin
         if (b[i]) begin
            run++;
            if (run == 6) begin
               s++;
               run = 0;
            end
         end else begin
            run = 0;
         end
      end
      return s;
   endfunction

   task automatic send(input logic [1:0] cls, input logic [3:0] p,
                       input logic [6:0] a, input logic [3:0] e,
                       input logic [63:0] pay, input logic [3:0] len,
                       input logic [15:0] crc, input bit hold);
      exp_t x;
      int n;
      int lat;
      logic [7:0] pb;
      x.nb = 0;
      x.bits = '0;
      for (int i = 0; i < 8; i++) begin x.bits[x.nb] = (i == 7); x.nb++; end
      pb = {~p, p};
      for (int i = 0; i < 8; i++) begin x.bits[x.nb] = pb[i]; x.nb++; end
      if (cls == 2'b00) begin
         for (int i = 0; i < 7; i++) begin x.bits[x.nb] = a[i]; x.nb++; end
         for (int i = 0; i < 4; i++) begin x.bits[x.nb] = e[i]; x.nb++; end
         for (int i = 4; i >= 0; i--) begin x.bits[x.nb] = crc[i]; x.nb++; end
      end else if (cls == 2'b01) begin
         n = (len > 8) ? 8 : int'(len);
         for (int j = 0; j < n; j++)
            for (int i = 0; i < 8; i++) begin
               x.bits[x.nb] = pay[8*j+i];
               x.nb++;
            end
         for (int i = 15; i >= 0; i--) begin x.bits[x.nb] = crc[i]; x.nb++; end
      end
      x.nst = stuff_count(x.bits, x.nb);
      sbq.push_back(x);
      @(negedge clock);
      start = 1'b1;
      pkt_class = cls;
      pid = p;
      addr = a;
      endp = e;
      payload = pay;
      payload_len = len;
      @(negedge clock);
      lat = 1;
      if (!hold) begin
         start = 1'b0;
         pid = ~p;
         addr = ~a;
         endp = ~e;
         payload = ~pay;
         payload_len = ~len;
      end
      while (!done && lat < 600) begin
         @(negedge clock);
         lat++;
      end
      if (done) begin
         chk("done_latency", lat, x.nb + x.nst + EOPN + 2);
      end else begin
         checks++;
         fails++;
         $display("FAIL done_timeout: got no done, required within 600 cycles");
      end
      start = 1'b0;
   endtask

   // Line monitor: decode each packet and compare with the queue head
   initial begin : monitor
      bit in_pkt;
      logic prev, b, last_en, last_done;
      int run, nbit, nse0, nj, cyc, nst, serr, maxrun;
      logic [127:0] got;
      exp_t x;
      in_pkt = 0;
      last_en = 0;
      last_done = 0;
      prev = 1;
      run = 0; nbit = 0; nse0 = 0; nj = 0;
      cyc = 0; nst = 0; serr = 0; maxrun = 0;
      got = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            in_pkt = 0;
            last_en = 0;
            last_done = 0;
         end else begin
            if (bus_en) begin
               if (!in_pkt) begin
                  in_pkt = 1;
                  prev = 1'b1;
                  run = 0; nbit = 0; nse0 = 0; nj = 0;
                  cyc = 0; nst = 0; serr = 0; maxrun = 0;
                  got = '0;
               end
               cyc++;
               if (dp != dm) begin
                  if (nse0 > 0) begin
                     nj++;
                  end else begin
                     b = (dp == prev);
                     prev = dp;
                     if (run == 6) begin
                        nst++;
                        if (b) serr++;
                        run = 0;
                     end else begin
                        if (nbit < 128) got[nbit] = b;
                        nbit++;
                        run = b ? run + 1 : 0;
                        if (run > maxrun) maxrun = run;
                     end
                  end
               end else if (!dp) begin
                  nse0++;
               end else begin
                  serr++;
               end
            end
            if (done) begin
               dones++;
               pkts++;
               chk("done_pulse_width", int'(last_done), 0);
               chk("busy_at_done", int'(busy), 0);
               chk("bus_en_at_done", int'(bus_en), 0);
               chk("bus_en_before_done", int'(last_en), 1);
               if (sbq.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_packet: got packet %0d, required none", pkts);
               end else begin
                  x = sbq.pop_front();
                  chk("bit_count", nbit, x.nb);
                  checks++;
                  if (got !== x.bits) begin
                     fails++;
                     $display("FAIL bits: got %h required %h", got, x.bits);
                  end
                  chk("stuff_count", nst, x.nst);
                  chk("stuff_errors", serr, 0);
                  chk("max_run_le6", int'(maxrun <= 6), 1);
                  chk("se0_cycles", nse0, EOPN);
                  chk("eop_j", nj, 1);
                  chk("bus_cycles", cyc, x.nb + x.nst + EOPN + 1);
               end
               in_pkt = 0;
            end
            last_en = bus_en;
            last_done = done;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0;
      logic [63:0] ff8;
      logic [63:0] mix;
      ff8 = {8{8'hFF}};
      mix = 64'h7E81F00FC33C5AA5;
      reset_n = 1'b1;
      start = 1'b0;
      pkt_class = '0;
      pid = '0;
      addr = '0;
      endp = '0;
      payload = '0;
      payload_len = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_bus_en", int'(bus_en), 0);
      chk("reset_dp", int'(dp), 1);
      chk("reset_dm", int'(dm), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      send(2'b10, 4'h2, 7'h00, 4'h0, 64'h0, 4'd0, 16'h0000, 0);
      send(2'b00, 4'h1, 7'h15, 4'hE, 64'h0, 4'd0, 16'h0017, 0);
      send(2'b01, 4'h3, 7'h00, 4'h0, 64'h03020100, 4'd4, 16'hF75E, 0);
      send(2'b01, 4'hB, 7'h00, 4'h0, ff8, 4'd8, crc16_ref(ff8, 8), 0);
      send(2'b01, 4'h3, 7'h00, 4'h0, 64'hDEAD, 4'd0, 16'h0000, 0);
      send(2'b01, 4'hB, 7'h00, 4'h0, mix, 4'd9, crc16_ref(mix, 8), 0);
      send(2'b10, 4'hA, 7'h00, 4'h0, 64'h0, 4'd0, 16'h0000, 1);
      repeat (30) @(negedge clock);
      chk("idle_after_hold", int'(busy), 0);

      d0 = dones;
      @(negedge clock);
      start = 1'b1;
      pkt_class = 2'b01;
      pid = 4'h3;
      payload = ff8;
      payload_len = 4'd8;
      @(negedge clock);
      start = 1'b0;
      repeat (24) @(negedge clock);
      chk("pre_reset_bus_en", int'(bus_en), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_reset_bus_en", int'(bus_en), 0);
      chk("mid_reset_busy", int'(busy), 0);
      chk("mid_reset_dp", int'(dp), 1);
      chk("mid_reset_dm", int'(dm), 0);
      repeat (4) @(negedge clock);
      chk("no_done_on_reset", dones, d0);
      reset_n = 1'b1;
      @(negedge clock);
      send(2'b11, 4'h2, 7'h00, 4'h0, 64'h0, 4'd0, 16'h0000, 0);

      repeat (10) @(negedge clock);
      chk("queue_empty", sbq.size(), 0);
      chk("packet_count", pkts, 8);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/usb_tx_packet_encoder.md
Name: usb_tx_packet_encoder

Overview:
Parametrised USB low-level packet transmitter. It generalises the single hard-wired OUT-token sender to three packet classes: token (CRC5), data (CRC16, 0..MAX_BYTES payload) and handshake (PID only). Every class gets on-the-fly bit stuffing, NRZI encoding and EOP generation. It sits between the host protocol FSM and the D+/D- tri-state drivers, and transmits one bus bit per clock.

Parameters:
MAX_BYTES, 8, maximum data-packet payload in bytes (>=1)
EOP_SE0_CYCLES, 2, number of SE0 bit times in EOP before the trailing J

Ports:
clock  input  1  bit-rate clock; all state changes on posedge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
pkt_class  input  2  00 token, 01 data, 10 handshake, 11 reserved (treated as handshake)
pid  input  4  PID code; encoder sends {~pid,pid}
addr  input  7  token address
endp  input  4  token endpoint
payload  input  8*MAX_BYTES  data bytes; byte i = payload[8i+7:8i]
payload_len  input  $clog2(MAX_BYTES+1)  number of payload bytes
busy  output  1  high from accepted start until the cycle done pulses
done  output  1  one-cycle pulse after the bus is released
bus_en  output  1  drive-enable for D+/D-
dp  output  1  D+ value when bus_en=1
dm  output  1  D- value when bus_en=1

Behaviour:
- Reset (async, any state): busy=0, done=0, bus_en=0, dp=1, dm=0 (J); FSM=IDLE; NRZI level=J; ones-run=0. Reset mid-packet releases the bus immediately, and no done is produced.
- Accept: in IDLE, start=1 at posedge → latch all inputs, busy=1, FSM=SYNC. The first SYNC bit is on the bus in the following cycle. Inputs are don't-care after acceptance. start while busy=1 is ignored.
- FSM: IDLE → SYNC(8) → PID(8) → {token: TOKEN(11) → CRC(5); data: DATA(8*len) → CRC(16); handshake: none} → EOP_SE0(EOP_SE0_CYCLES) → EOP_J(1) → DONE → IDLE.
- Field order:
  - SYNC bits 0000_0001 in transmission order.
  - PID byte LSB first.
  - addr LSB first, then endp LSB first.
  - payload bytes in ascending index, each LSB first.
- CRC5: poly x^5+x^2+1, init 5'h1F, computed over the 11 token bits in transmission order; the ones-complement is sent highest-order bit first.
- CRC16: poly 0x8005, init 16'hFFFF, computed over payload bits in transmission order; the complement is sent highest-order bit first.
- payload_len > MAX_BYTES is clamped to MAX_BYTES. payload_len=0 sends PID then CRC16 = 16'h0000.
- Bit stuffing applies from SYNC through the last CRC bit:
  - After six consecutive 1s, insert one 0 and stall the field/bit counter for that cycle; the CRC does not see stuffed bits.
  - The run counter clears on any 0, real or stuffed, and persists across field boundaries.
  - A run of six ending on the last CRC bit still gets its stuffed 0 before EOP.
- NRZI: a 0 toggles the line level and a 1 holds it; the level starts at J each packet. J = dp1/dm0, K = dp0/dm1.
- EOP: dp=dm=0 for EOP_SE0_CYCLES cycles, then J for 1 cycle with bus_en=1. Next cycle: bus_en=0, done=1, busy=0.
- bus_en is high from the first SYNC bit through EOP_J inclusive.
- Back-to-back: start sampled in the DONE cycle is ignored; the earliest accept is the cycle after done.

Test Plan:
- Handshake ACK (pid=4'h2): bus_en high for exactly 8+8+2+1=19 cycles. Line sequence is KJKJKJKK then the NRZI of 8'hD2 LSB-first, no stuffing, then SE0,SE0,J. done pulses once on cycle 20 after accept.
- Token OUT (pid=4'h1), addr=7'h15, endp=4'hE: transmitted CRC5 field = ~5'h17 residual form, matching the known-good value; total bit count 32 plus the stuffed zeros checked by a reference decoder.
- Data0 (pid=4'h3), payload_len=4, bytes 00 01 02 03: CRC16 field = 16'hF75E. The bench de-NRZIs, de-stuffs and recovers exact bytes plus CRC.
- Stuffing stress: data payload 8×8'hFF, MAX_BYTES=8 → a 0 is inserted after every six 1s, including across byte and CRC boundaries. Bus time = expected bits + floor-count of stuffs; a max run of six 1s is observed on the decoded stream.
- Boundaries:
  - payload_len=0 → PID + 16 zero CRC bits.
  - payload_len=9 with MAX_BYTES=8 → exactly 8 bytes sent.
  - start held high while busy → only one packet.
- Reset mid-packet: assert reset_n=0 during the DATA field → bus_en=0 and busy=0 asynchronously, no done. After release, a fresh ACK packet transmits correctly, starting from J.
